mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
// Memory-side responder for the LSU request port, plus the instruction-fetch port. Accepts load/store
// requests of 1/2/4 bytes and serialises them onto the byte-wide RAM bus. Returns a one-cycle finish
// pulse and the assembled load data. Arbitrates LSU against ifetch and stalls I/O writes while the
// I/O buffer is full.
// PARAMETERS
// IO_ADDR_HI  2'b11  value of addr[17:16] that selects the I/O region (subject to io_buffer_full stall)
// PORTS
// clk                          in   1   clock
// rst                          in   1   synchronous, active-high reset
// rdy                          in   1   global ready; low = freeze all state, outputs hold
// enable_signal_from_lsu       in   1   one-cycle request pulse from LSU
// address_from_lsu             in   32  byte address
// data_from_lsu                in   32  store data, byte 0 = bits[7:0]
// read_or_write_flag_from_lsu  in   1   0 = READ, 1 = WRITE
// size_from_lsu                in   3   byte count: 1, 2 or 4
// finish_flag_to_lsu           out  1   one-cycle completion pulse
// data_to_lsu                  out  32  raw little-endian load data, upper bytes zero for size < 4
// enable_signal_from_ifetch    in   1   level request, held until finish
// address_from_ifetch          in   32  fetch address, always a 4-byte read
// finish_flag_to_ifetch        out  1   one-cycle completion pulse
// inst_to_ifetch               out  32  fetched word
// misbranch_flag               in   1   flush: abort fetches and loads, never stores
// io_buffer_full               in   1   I/O write buffer full
// mem_din                      in   8   RAM read byte (address presented in the previous cycle)
// mem_dout                     out  8   RAM write byte
// mem_a                        out  32  RAM byte address
// mem_wr                       out  1   1 = write mem_dout to mem_a this cycle
// BEHAVIOUR
// - Reset: state IDLE; pend_valid = 0; cnt = 0.
//   All outputs 0: both finish flags, data_to_lsu, inst_to_ifetch, mem_a, mem_dout, mem_wr.
// - rdy = 0: no register changes. mem_wr is forced to 0.
// - States: IDLE, LSU_RD, LSU_WR, IF_RD. A 3-bit cnt counts bytes issued.
// - LSU request capture: on an edge where enable_signal_from_lsu = 1, latch address/data/rw/size into
//   the pending slot (pend_valid = 1).
//   - In IDLE, that capture and the dispatch happen on the same edge.
//   - LSU never issues a new pulse before finish_flag_to_lsu, so the slot depth is 1.
// - Arbitration in IDLE: pending (or arriving) LSU request wins over ifetch. No preemption once
//   started. An arriving LSU pulse during IF_RD waits in the slot.
// - Read, n = size bytes, dispatched at edge E:
//   - In cycle cnt (0..n-1): mem_a = addr + cnt, mem_wr = 0.
//   - At each edge with cnt >= 1, capture mem_din into byte cnt-1.
//   - The last byte is captured at edge E+n+1. On that edge: finish pulse, data valid, state IDLE.
//   - Data output holds until the next completion.
// - Write, n bytes, dispatched at edge E:
//   - In cycle cnt: mem_a = addr + cnt, mem_dout = data[8*cnt+7 : 8*cnt], mem_wr = 1.
//   - Finish pulse is registered at edge E+n; state IDLE.
// - I/O stall: while addr[17:16] == IO_ADDR_HI and io_buffer_full = 1 in LSU_WR, force mem_wr = 0
//   and do not advance cnt.
// - IF_RD: a 4-byte read using address_from_ifetch. Completes with finish_flag_to_ifetch /
//   inst_to_ifetch.
// - Finish flags are high for exactly one cycle. They are never high in the same cycle as each other.
// - misbranch_flag = 1 at an edge:
//   - In IF_RD or LSU_RD: go to IDLE, no finish pulse, mem outputs 0 next cycle.
//   - A pending read in the slot is cleared.
//   - LSU_WR and pending writes are unaffected.
// - Reset mid-operation: the operation is abandoned. No finish pulse. mem_wr = 0 in the next cycle.
// - Address increment wraps modulo 2^32.
// TESTING
// 1. RAM[0x1000..0x1003] = 11,22,33,44; LW pulse at edge E -> finish_flag_to_lsu high after E+5 only;
//    data_to_lsu = 0x44332211.
// 2. LH at 0x1002 -> mem_a = 0x1002, 0x1003; data_to_lsu = 0x00004433. LB -> 0x00000011.
// 3. SW 0xDEADBEEF @0x2000 -> mem_wr for 4 cycles, bytes EF, BE, AD, DE at 0x2000..0x2003;
//    finish at E+4.
// 4. SB 0x41 @0x30000 with io_buffer_full high 3 cycles -> mem_wr = 0 for 3 cycles, then one write;
//    finish at E+4.
// 5. ifetch held and LSU pulse on the same edge -> LSU served first, then fetch.
//    LSU pulse during IF_RD -> served right after the fetch finish.
// 6. misbranch during LW (cnt = 2) -> no finish, IDLE. misbranch during SW -> store completes.
//    rdy low mid-read -> timing stretched, data still correct.

Source files
------------

// File: rtl/mem_ctrl.sv
// Memory-side responder: serialises 1/2/4-byte LSU loads/stores and 4-byte instruction
// fetches onto a byte-wide RAM bus, with LSU priority, misbranch flush and I/O write stall.
module mem_ctrl #(
  parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        enable_signal_from_lsu,
  input  logic [31:0] address_from_lsu,
  input  logic [31:0] data_from_lsu,
  input  logic        read_or_write_flag_from_lsu,
  input  logic [2:0]  size_from_lsu,
  output logic        finish_flag_to_lsu,
  output logic [31:0] data_to_lsu,
  input  logic        enable_signal_from_ifetch,
  input  logic [31:0] address_from_ifetch,
  output logic        finish_flag_to_ifetch,
  output logic [31:0] inst_to_ifetch,
  input  logic        misbranch_flag,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LSU_RD = 2'd1,
    LSU_WR = 2'd2,
    IF_RD  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;

  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic [31:0] pend_data_q, pend_data_d;
  logic        pend_rw_q, pend_rw_d;
  logic [2:0]  pend_size_q, pend_size_d;

  logic [31:0] cur_addr_q, cur_addr_d;
  logic [2:0]  cur_size_q, cur_size_d;
  logic [31:0] rbuf_q, rbuf_d;

  logic        finish_lsu_q, finish_lsu_d;
  logic        finish_if_q, finish_if_d;
  logic [31:0] lsu_data_q, lsu_data_d;
  logic [31:0] inst_q, inst_d;

  logic        io_stall;
  logic [31:0] byte_addr;
  logic [4:0]  rd_off;
  logic [4:0]  wr_off;
  logic [1:0]  rd_idx;

  assign byte_addr = cur_addr_q + {29'd0, cnt_q};
  assign io_stall  = (state_q == LSU_WR) && (cur_addr_q[17:16] == IO_ADDR_HI) && io_buffer_full;
  assign rd_idx    = cnt_q[1:0] - 2'd1;
  assign rd_off    = {rd_idx, 3'b000};
  assign wr_off    = {cnt_q[1:0], 3'b000};

  assign finish_flag_to_lsu    = finish_lsu_q;
  assign data_to_lsu           = lsu_data_q;
  assign finish_flag_to_ifetch = finish_if_q;
  assign inst_to_ifetch        = inst_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    pend_rw_d    = pend_rw_q;
    pend_size_d  = pend_size_q;
    cur_addr_d   = cur_addr_q;
    cur_size_d   = cur_size_q;
    rbuf_d       = rbuf_q;
    finish_lsu_d = 1'b0;
    finish_if_d  = 1'b0;
    lsu_data_d   = lsu_data_q;
    inst_d       = inst_q;

    if (enable_signal_from_lsu) begin
      pend_valid_d = 1'b1;
      pend_addr_d  = address_from_lsu;
      pend_data_d  = data_from_lsu;
      pend_rw_d    = read_or_write_flag_from_lsu;
      pend_size_d  = size_from_lsu;
    end
    // A flush drops a waiting (or just-arriving) load; stores always survive.
    if (misbranch_flag && !pend_rw_d) begin
      pend_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        cnt_d = 3'd0;
        if (pend_valid_d) begin
          pend_valid_d = 1'b0;
          cur_addr_d   = pend_addr_d;
          cur_size_d   = pend_size_d;
          rbuf_d       = '0;
          state_d      = pend_rw_d ? LSU_WR : LSU_RD;
        end else if (enable_signal_from_ifetch && !misbranch_flag) begin
          cur_addr_d = address_from_ifetch;
          cur_size_d = 3'd4;
          rbuf_d     = '0;
          state_d    = IF_RD;
        end
      end
      LSU_RD, IF_RD: begin
        if (misbranch_flag) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else begin
          if (cnt_q != 3'd0) begin
            rbuf_d[rd_off +: 8] = mem_din;
          end
          if (cnt_q == cur_size_q) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
            if (state_q == LSU_RD) begin
              finish_lsu_d = 1'b1;
              lsu_data_d   = rbuf_d;
            end else begin
              finish_if_d = 1'b1;
              inst_d      = rbuf_d;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      LSU_WR: begin
        if (!io_stall) begin
          if (cnt_q == cur_size_q - 3'd1) begin
            state_d      = IDLE;
            cnt_d        = 3'd0;
            finish_lsu_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // While frozen, a read re-presents the previous byte address so that the byte
  // sampled on the first edge after rdy returns is still the one cnt expects.
  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    unique case (state_q)
      LSU_RD, IF_RD: begin
        if (!rdy) begin
          if (cnt_q != 3'd0) mem_a = byte_addr - 32'd1;
        end else if (cnt_q != cur_size_q) begin
          mem_a = byte_addr;
        end
      end
      LSU_WR: begin
        mem_a    = byte_addr;
        mem_dout = pend_data_q[wr_off +: 8];
        mem_wr   = rdy && !io_stall;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      pend_rw_q    <= 1'b0;
      pend_size_q  <= '0;
      cur_addr_q   <= '0;
      cur_size_q   <= '0;
      rbuf_q       <= '0;
      finish_lsu_q <= 1'b0;
      finish_if_q  <= 1'b0;
      lsu_data_q   <= '0;
      inst_q       <= '0;
    end else if (rdy) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      pend_rw_q    <= pend_rw_d;
      pend_size_q  <= pend_size_d;
      cur_addr_q   <= cur_addr_d;
      cur_size_q   <= cur_size_d;
      rbuf_q       <= rbuf_d;
      finish_lsu_q <= finish_lsu_d;
      finish_if_q  <= finish_if_d;
      lsu_data_q   <= lsu_data_d;
      inst_q       <= inst_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM environment plus a transaction-level model of memory contents
// and expected latencies; directed scenarios followed by randomized loads/stores.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        enable_signal_from_lsu = 1'b0;
  logic [31:0] address_from_lsu = '0;
  logic [31:0] data_from_lsu = '0;
  logic        read_or_write_flag_from_lsu = 1'b0;
  logic [2:0]  size_from_lsu = '0;
  logic        finish_flag_to_lsu;
  logic [31:0] data_to_lsu;
  logic        enable_signal_from_ifetch = 1'b0;
  logic [31:0] address_from_ifetch = '0;
  logic        finish_flag_to_ifetch;
  logic [31:0] inst_to_ifetch;
  logic        misbranch_flag = 1'b0;
  logic        io_buffer_full = 1'b0;
  logic [7:0]  mem_din = '0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  always #5 clk = ~clk;

  mem_ctrl #(.IO_ADDR_HI(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .enable_signal_from_lsu(enable_signal_from_lsu),
    .address_from_lsu(address_from_lsu),
    .data_from_lsu(data_from_lsu),
    .read_or_write_flag_from_lsu(read_or_write_flag_from_lsu),
    .size_from_lsu(size_from_lsu),
    .finish_flag_to_lsu(finish_flag_to_lsu),
    .data_to_lsu(data_to_lsu),
    .enable_signal_from_ifetch(enable_signal_from_ifetch),
    .address_from_ifetch(address_from_ifetch),
    .finish_flag_to_ifetch(finish_flag_to_ifetch),
    .inst_to_ifetch(inst_to_ifetch),
    .misbranch_flag(misbranch_flag),
    .io_buffer_full(io_buffer_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  // RAM environment: 64 KiB aliased on addr[15:0], one-cycle read latency.
  logic [7:0]  ram [65536];
  logic        pre_en = 1'b0;
  logic [31:0] pre_addr = '0;
  logic [7:0]  pre_data = '0;
  int          wr_count = 0;

  always @(posedge clk) begin
    if (pre_en) begin
      ram[pre_addr[15:0]] <= pre_data;
    end else if (mem_wr) begin
      ram[mem_a[15:0]] <= mem_dout;
      wr_count <= wr_count + 1;
    end
    mem_din <= ram[mem_a[15:0]];
  end

  // Reference memory contents at full 32-bit addresses.
  logic [7:0]  mdl [logic [31:0]];
  logic [31:0] last_ld = '0;
  int passed = 0;
  int fails  = 0;
  int total  = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] mdl_rd(input logic [31:0] a);
    if (mdl.exists(a)) return mdl[a];
    return 8'h00;
  endfunction

  function automatic logic [31:0] mdl_word(input logic [31:0] a, input int n);
    logic [31:0] w = '0;
    for (int i = 0; i < n; i++) w[8*i +: 8] = mdl_rd(a + 32'(i));
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pre(input logic [31:0] a, input logic [7:0] b);
    pre_en = 1'b1; pre_addr = a; pre_data = b; mdl[a] = b;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Issue one LSU pulse and wait for finish; d counts negedges after the dispatch edge.
  task automatic lsu_op(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] size, input int rdy_at, input int rdy_len,
                        input int full_len, input int mis_at,
                        output int lat, output logic [31:0] rdata);
    enable_signal_from_lsu = 1'b1;
    address_from_lsu = addr;
    data_from_lsu = wdata;
    read_or_write_flag_from_lsu = rw;
    size_from_lsu = size;
    io_buffer_full = (full_len > 0);
    lat = -1;
    rdata = '0;
    for (int d = 0; d < 40; d++) begin
      @(negedge clk);
      enable_signal_from_lsu = 1'b0;
      if (finish_flag_to_lsu) begin
        lat = d;
        rdata = data_to_lsu;
        break;
      end
      rdy = !(d >= rdy_at && d < rdy_at + rdy_len);
      io_buffer_full = (d < full_len);
      misbranch_flag = (d == mis_at);
    end
    rdy = 1'b1;
    io_buffer_full = 1'b0;
    misbranch_flag = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] size,
                         input int rdy_at, input int rdy_len);
    int lat;
    logic [31:0] rd;
    logic [31:0] exp = mdl_word(addr, int'(size));
    lsu_op(1'b0, addr, '0, size, rdy_at, rdy_len, 0, -1, lat, rd);
    check({tag, "_lat"}, lat, 32'(int'(size) + 1 + rdy_len));
    check({tag, "_data"}, rd, exp);
    last_ld = exp;
    if (lat >= 0) begin
      @(negedge clk);
      check({tag, "_pulse"}, 32'(finish_flag_to_lsu), 32'd0);
    end
  endtask

  task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] size, input int rdy_at, input int rdy_len,
                          input int full_len, input int mis_at);
    int lat;
    logic [31:0] rd;
    int wc0 = wr_count;
    lsu_op(1'b1, addr, wdata, size, rdy_at, rdy_len, full_len, mis_at, lat, rd);
    check({tag, "_lat"}, lat, 32'(int'(size) + rdy_len + full_len));
    check({tag, "_nwr"}, wr_count - wc0, 32'(int'(size)));
    for (int i = 0; i < int'(size); i++) begin
      mdl[addr + 32'(i)] = wdata[8*i +: 8];
      check({tag, "_byte"}, 32'(ram[16'(addr + 32'(i))]), 32'(wdata[8*i +: 8]));
    end
    if (lat >= 0) begin
      @(negedge clk);
      check({tag, "_pulse"}, 32'(finish_flag_to_lsu), 32'd0);
    end
  endtask

  // Fetch held from d=-1; optional LSU pulse (caller sets fields) and misbranch at given d.
  task automatic fetch_run(input logic [31:0] faddr, input int pulse_at, input int mis_at,
                           output int lat_l, output int lat_i, output logic [31:0] dl,
                           output logic [31:0] di, output int both, output int nfin);
    enable_signal_from_ifetch = 1'b1;
    address_from_ifetch = faddr;
    enable_signal_from_lsu = (pulse_at == -1);
    lat_l = -1; lat_i = -1; dl = '0; di = '0; both = 0; nfin = 0;
    for (int d = 0; d < 30; d++) begin
      @(negedge clk);
      if (finish_flag_to_lsu && finish_flag_to_ifetch) both++;
      if (finish_flag_to_lsu) nfin++;
      if (finish_flag_to_ifetch) nfin++;
      if (finish_flag_to_lsu && lat_l < 0) begin
        lat_l = d;
        dl = data_to_lsu;
      end
      if (finish_flag_to_ifetch && lat_i < 0) begin
        lat_i = d;
        di = inst_to_ifetch;
        enable_signal_from_ifetch = 1'b0;
      end
      enable_signal_from_lsu = (d == pulse_at);
      misbranch_flag = (d == mis_at);
      if (d == mis_at) enable_signal_from_ifetch = 1'b0;
    end
    enable_signal_from_ifetch = 1'b0;
    misbranch_flag = 1'b0;
  endtask

  initial begin
    int lat, lat_l, lat_i, both, nfin, wc0, fin_seen;
    logic [31:0] rd, dl, di, addr, wdata;
    logic [2:0] sz;
    logic rw;
    int rdy_at, rdy_len;

    @(negedge clk);
    pre(32'h1000, 8'h11); pre(32'h1001, 8'h22); pre(32'h1002, 8'h33); pre(32'h1003, 8'h44);
    pre(32'hFFFF_FFFE, 8'hA1); pre(32'hFFFF_FFFF, 8'hB2);
    pre(32'h0000_0000, 8'hC3); pre(32'h0000_0001, 8'hD4);
    for (int unsigned i = 0; i < 128; i++) pre(32'h4000 + i, 8'($urandom));

    check("rst_fin_lsu", 32'(finish_flag_to_lsu), 32'd0);
    check("rst_fin_if", 32'(finish_flag_to_ifetch), 32'd0);
    check("rst_data", data_to_lsu, 32'd0);
    check("rst_inst", inst_to_ifetch, 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_dout", 32'(mem_dout), 32'd0);
    check("rst_wr", 32'(mem_wr), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_load("lw", 32'h1000, 3'd4, 99, 0);
    check("lw_value", last_ld, 32'h4433_2211);
    do_load("lh", 32'h1002, 3'd2, 99, 0);
    do_load("lb", 32'h1000, 3'd1, 99, 0);
    do_load("lw_wrap", 32'hFFFF_FFFE, 3'd4, 99, 0);

    do_store("sw", 32'h2000, 32'hDEAD_BEEF, 3'd4, 99, 0, 0, -1);
    do_load("sw_rb", 32'h2000, 3'd4, 99, 0);
    do_store("sb_io", 32'h0003_0040, 32'h0000_0041, 3'd1, 99, 0, 3, -1);
    do_store("sh_io_free", 32'h0003_0050, 32'h0000_9A7B, 3'd2, 99, 0, 0, -1);

    // Fetch and LSU on the same edge: LSU first, fetch after.
    address_from_lsu = 32'h1000; read_or_write_flag_from_lsu = 1'b0; size_from_lsu = 3'd4;
    fetch_run(32'h4020, -1, -1, lat_l, lat_i, dl, di, both, nfin);
    check("arb_lsu_lat", lat_l, 32'd5);
    check("arb_lsu_data", dl, mdl_word(32'h1000, 4));
    check("arb_if_lat", lat_i, 32'd11);
    check("arb_if_inst", di, mdl_word(32'h4020, 4));
    check("arb_both", both, 32'd0);
    check("arb_nfin", nfin, 32'd2);

    // LSU pulse during fetch waits in the slot.
    address_from_lsu = 32'h1001; size_from_lsu = 3'd1;
    fetch_run(32'h4030, 1, -1, lat_l, lat_i, dl, di, both, nfin);
    check("slot_if_lat", lat_i, 32'd5);
    check("slot_if_inst", di, mdl_word(32'h4030, 4));
    check("slot_lsu_lat", lat_l, 32'd8);
    check("slot_lsu_data", dl, 32'h0000_0022);
    check("slot_both", both, 32'd0);
    last_ld = 32'h0000_0022;

    // Misbranch kills the fetch and the waiting load.
    address_from_lsu = 32'h1002; size_from_lsu = 3'd1;
    fetch_run(32'h4040, 1, 2, lat_l, lat_i, dl, di, both, nfin);
    check("mb_pend_rd_nfin", nfin, 32'd0);
    check("mb_pend_rd_hold", data_to_lsu, last_ld);

    // Misbranch kills the fetch but a waiting store still runs.
    address_from_lsu = 32'h2100; data_from_lsu = 32'h0000_005A;
    read_or_write_flag_from_lsu = 1'b1; size_from_lsu = 3'd1;
    fetch_run(32'h4050, 1, 2, lat_l, lat_i, dl, di, both, nfin);
    mdl[32'h2100] = 8'h5A;
    check("mb_pend_wr_lat", lat_l, 32'd5);
    check("mb_pend_wr_if", lat_i, -1);
    check("mb_pend_wr_byte", 32'(ram[16'h2100]), 32'h5A);

    // Misbranch in LW at cnt=2: abandoned, bus idle afterwards.
    lsu_op(1'b0, 32'h1000, '0, 3'd4, 99, 0, 0, 2, lat, rd);
    check("mb_lw_nofin", lat, -1);
    check("mb_lw_hold", data_to_lsu, last_ld);
    check("mb_lw_mem_a", mem_a, 32'd0);
    check("mb_lw_wr", 32'(mem_wr), 32'd0);
    do_load("after_mb", 32'h1000, 3'd4, 99, 0);

    do_store("sw_mb", 32'h2010, 32'h1234_5678, 3'd4, 99, 0, 0, 1);
    do_load("rdy_lw", 32'h4010, 3'd4, 2, 3);
    do_load("rdy_lw0", 32'h4014, 3'd4, 0, 2);
    do_store("rdy_sw", 32'h2020, 32'hCAFE_F00D, 3'd4, 1, 2, 0, -1);

    // Reset in the middle of a store.
    wc0 = wr_count;
    enable_signal_from_lsu = 1'b1; address_from_lsu = 32'h2200; data_from_lsu = 32'h8877_6655;
    read_or_write_flag_from_lsu = 1'b1; size_from_lsu = 3'd4;
    @(negedge clk);
    enable_signal_from_lsu = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_wr", 32'(mem_wr), 32'd0);
    check("rst_mid_data", data_to_lsu, 32'd0);
    fin_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (finish_flag_to_lsu) fin_seen++;
    end
    check("rst_mid_nofin", fin_seen, 32'd0);
    check("rst_mid_nwr", wr_count - wc0, 32'd2);
    mdl[32'h2200] = 8'h55;
    mdl[32'h2201] = 8'h66;
    do_load("rst_mid_rb", 32'h2200, 3'd2, 99, 0);

    for (int k = 0; k < 24; k++) begin
      rw = 1'($urandom_range(0, 1));
      sz = 3'(1 << $urandom_range(0, 2));
      addr = 32'h4000 + 32'($urandom_range(0, 120));
      wdata = $urandom;
      rdy_at = $urandom_range(0, int'(sz) - 1);
      rdy_len = $urandom_range(0, 2);
      if (rw) do_store("rnd_st", addr, wdata, sz, rdy_at, rdy_len, 0, -1);
      else    do_load("rnd_ld", addr, sz, rdy_at, rdy_len);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
